arbitro_escrita_reg: RTL and testbench

Shares the single write port of the 64x32 register file between N write requesters (ALU writeback, memory load, I/O input, ...). Uses round-robin arbitration with valid/ready handshakes and drives registered write signals (reg_write, reg_escrita, escreve_dado) straight into the register file. Includes a clear sequencer that zeroes all 64 registers after reset, or on request, before any requester is served.

---
 rtl/arbitro_escrita_reg.sv | 70 +++++++
 tb/tb_arbitro_escrita_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/arbitro_escrita_reg.sv
// arbitro_escrita_reg: round-robin arbiter for the register file write port, with a
// clear sequencer that zeroes every register before requesters are served.
module arbitro_escrita_reg #(
  parameter int N_REQ = 3,
  parameter int N_REGS = 64,
  parameter int LARG = 32,
  parameter int LIMPA_INICIAL = 1,
  parameter int PROTEGE_ZERO = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valido,
  input  logic [6*N_REQ-1:0]    req_reg,
  input  logic [LARG*N_REQ-1:0] req_dado,
  output logic [N_REQ-1:0]      req_pronto,
  input  logic                  limpa_req,
  output logic                  reg_write,
  output logic [5:0]            reg_escrita,
  output logic [LARG-1:0]       escreve_dado,
  output logic                  ocupado
);
  localparam int PW = $clog2(N_REQ);
  localparam logic LIMPA = 1'b0;
  localparam logic ATIVO = 1'b1;
  localparam logic [5:0] ULTIMO = 6'(N_REGS - 1);
  logic estado;
  logic [5:0] cnt;
  logic [PW-1:0] ptr, sel;
  logic achou, aceita;
  logic [5:0] sel_reg;
  logic [LARG-1:0] sel_dado;
  // Scan downward so the candidate closest to ptr is the last one to win.
  always_comb begin
    sel = '0;
    achou = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valido[(int'(ptr) + k) % N_REQ]) begin
        sel = PW'((int'(ptr) + k) % N_REQ);
        achou = 1'b1;
      end
  end
  assign aceita = estado == ATIVO && !limpa_req && achou;
  assign req_pronto = aceita ? N_REQ'(1) << sel : '0;
  assign sel_reg = req_reg[6*int'(sel) +: 6];
  assign sel_dado = req_dado[LARG*int'(sel) +: LARG];
  assign ocupado = estado == LIMPA;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado <= LIMPA_INICIAL != 0 ? LIMPA : ATIVO;
      cnt <= '0;
      ptr <= '0;
      reg_write <= 1'b0;
      reg_escrita <= '0;
      escreve_dado <= '0;
    end else if (estado == LIMPA) begin
      reg_write <= 1'b1;
      reg_escrita <= cnt;
      escreve_dado <= '0;
      cnt <= cnt == ULTIMO ? '0 : cnt + 6'd1;
      if (cnt == ULTIMO) estado <= ATIVO;
    end else begin
      reg_write <= aceita && !(PROTEGE_ZERO != 0 && sel_reg == '0);
      if (aceita) begin
        reg_escrita <= sel_reg;
        escreve_dado <= sel_dado;
        ptr <= sel == PW'(N_REQ - 1) ? '0 : sel + PW'(1);
      end
      if (limpa_req) estado <= LIMPA;
    end
endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// tb_arbitro_escrita_reg: directed stimulus with a per-cycle reference model of the
// write-port arbiter and a shadow register file fed from the write outputs.
module tb_arbitro_escrita_reg;
  localparam int N = 3;
  localparam int L = 32;
  logic clock = 0, reset_n = 0, limpa_req = 0;
  logic [N-1:0] req_valido = '0, req_pronto;
  logic [6*N-1:0] req_reg = '0;
  logic [L*N-1:0] req_dado = '0;
  logic reg_write, ocupado;
  logic [5:0] reg_escrita;
  logic [L-1:0] escreve_dado;
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
  arbitro_escrita_reg #(.N_REQ(N), .N_REGS(64), .LARG(L), .LIMPA_INICIAL(1), .PROTEGE_ZERO(1)) dut (
    .clock(clock), .reset_n(reset_n), .req_valido(req_valido), .req_reg(req_reg),
    .req_dado(req_dado), .req_pronto(req_pronto), .limpa_req(limpa_req),
    .reg_write(reg_write), .reg_escrita(reg_escrita), .escreve_dado(escreve_dado),
    .ocupado(ocupado));
  logic [5:0] q_reg[N][$];
  logic [L-1:0] q_dat[N][$];
  logic [N-1:0] acc = '0;
  int clear_left = 64, nxt = 0, ocup_cycles = 0;
  logic m_we = 0;
  logic [5:0] m_idx = 0;
  logic [L-1:0] m_dat = 0;
  logic [L-1:0] rf[64];
  int glog[$];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int arb();
    for (int k = 0; k < N; k++)
      if (req_valido[(nxt + k) % N]) return (nxt + k) % N;
    return -1;
  endfunction
  always @(negedge clock) begin
    int g;
    logic [N-1:0] ep;
    if (!reset_n) begin
      clear_left = 64; nxt = 0; m_we = 0; m_idx = 0; m_dat = 0; acc = '0;
      chk("rst req_pronto", req_pronto, 0);
      chk("rst reg_write", reg_write, 0);
      chk("rst reg_escrita", reg_escrita, 0);
      chk("rst escreve_dado", escreve_dado, 0);
      chk("rst ocupado", ocupado, 1);
    end else begin
      g = (clear_left > 0 || limpa_req) ? -1 : arb();
      ep = g < 0 ? '0 : N'(1) << g;
      chk("req_pronto", req_pronto, ep);
      chk("reg_write", reg_write, m_we);
      chk("reg_escrita", reg_escrita, m_idx);
      chk("escreve_dado", escreve_dado, m_dat);
      chk("ocupado", ocupado, clear_left > 0);
      acc = req_valido & req_pronto;
      if (reg_write) rf[reg_escrita] = escreve_dado;
      if (ocupado) ocup_cycles++;
      if (clear_left > 0) begin
        m_we = 1; m_idx = 6'(64 - clear_left); m_dat = 0; clear_left--;
      end else if (limpa_req) begin
        m_we = 0; clear_left = 64;
      end else if (g >= 0) begin
        m_idx = req_reg[6*g +: 6]; m_dat = req_dado[L*g +: L];
        m_we = m_idx != 0; nxt = (g + 1) % N; glog.push_back(g);
      end else m_we = 0;
    end
  end
  task automatic tick(input logic lp = 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && q_reg[i].size() > 0) begin
        void'(q_reg[i].pop_front());
        void'(q_dat[i].pop_front());
      end
      req_valido[i] = q_reg[i].size() > 0;
      req_reg[6*i +: 6] = q_reg[i].size() > 0 ? q_reg[i][0] : 6'd0;
      req_dado[L*i +: L] = q_dat[i].size() > 0 ? q_dat[i][0] : '0;
    end
    limpa_req = lp;
  endtask
  task automatic push(input int i, input logic [5:0] r, input logic [L-1:0] d);
    q_reg[i].push_back(r);
    q_dat[i].push_back(d);
  endtask
  function automatic bit pendente();
    for (int i = 0; i < N; i++) if (q_reg[i].size() > 0) return 1;
    return 0;
  endfunction
  task automatic drain(input int budget);
    int c = 0;
    while (pendente() && c < budget) begin tick(); c++; end
    if (pendente()) begin
      n_cmp++; n_bad++;
      $display("FAIL drain timeout: requests still pending after %0d cycles", budget);
    end
    repeat (2) tick();
  endtask
  initial begin
    for (int r = 0; r < 4; r++) begin
      push(0, 6'd5, 32'hA); push(1, 6'd6, 32'hB); push(2, 6'd7, 32'hC);
    end
    repeat (3) tick();
    reset_n = 1;
    drain(200);
    chk("clear cycles", ocup_cycles, 64);
    for (int i = 0; i < 6; i++) chk("rr grant order", glog[i], i % 3);
    chk("rf[5]", rf[5], 32'hA);
    chk("rf[6]", rf[6], 32'hB);
    chk("rf[7]", rf[7], 32'hC);
    chk("rf[63] cleared", rf[63], 0);
    push(2, 6'd9, 32'hDEADBEEF);
    drain(20);
    chk("rf[9]", rf[9], 32'hDEADBEEF);
    chk("grant req2", glog[$], 2);
    push(1, 6'd0, 32'h1234);
    drain(20);
    chk("rf[0] protected", rf[0], 0);
    chk("grant req1", glog[$], 1);
    chk("ptr after idx0", nxt, 2);
    push(0, 6'd11, 32'h55);
    tick(1);
    drain(200);
    chk("rf[5] recleared", rf[5], 0);
    chk("rf[11]", rf[11], 32'h55);
    chk("grant req0 after clear", glog[$], 0);
    chk("clear cycles 2", ocup_cycles, 128);
    tick(1);
    repeat (21) tick();
    #2 reset_n = 0;
    #1;
    chk("async reg_write", reg_write, 0);
    chk("async reg_escrita", reg_escrita, 0);
    chk("async escreve_dado", escreve_dado, 0);
    chk("async ocupado", ocupado, 1);
    repeat (2) tick();
    #1 reset_n = 1;
    repeat (70) tick();
    chk("idle after reclear", ocupado, 0);
    chk("clear cycles 3", ocup_cycles, 212);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
